// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_unit
//  Purpose  : Resolves conditional branches and jumps in one cycle. It
//             computes the taken condition, target, next PC and link PC,
//             flags a mispredict against the fetched next PC, counts
//             mispredicts, and trains a table of 2-bit saturating counters
//             that answers taken/not-taken prediction queries.
//  Ports    : clk, rst_n (async, active-low)
//             valid_in, stall, flush  - request handshake and pipeline control
//             op[2:0]                 - EQ NE LT LTU GE GEU JAL JALR
//             pc, rs1, rs2, imm       - operands (imm is sign-extended)
//             pred_next_pc            - next PC the front end fetched
//             lookup_pc, predict_taken- combinational prediction query
//             valid_out, taken, next_pc, link_pc, mispredict - registered result
//             mispredict_count[15:0]  - saturating mispredict statistic
//  Revision : 1.0 - initial release
// ============================================================================
module branch_unit #(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pred_next_pc,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_taken,
  output logic            valid_out,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] link_pc,
  output logic            mispredict,
  output logic [15:0]     mispredict_count
);

  localparam int         c_BHT_ENTRIES = 1 << BHT_IDX;
  localparam logic [2:0] c_OP_EQ   = 3'b000;
  localparam logic [2:0] c_OP_NE   = 3'b001;
  localparam logic [2:0] c_OP_LT   = 3'b010;
  localparam logic [2:0] c_OP_LTU  = 3'b011;
  localparam logic [2:0] c_OP_GE   = 3'b100;
  localparam logic [2:0] c_OP_GEU  = 3'b101;
  localparam logic [2:0] c_OP_JAL  = 3'b110;
  localparam logic [2:0] c_OP_JALR = 3'b111;

  // --------------------------------------------------------------------------
  // Condition evaluation
  // --------------------------------------------------------------------------
  logic w_eq;
  logic w_lt;
  logic w_ltu;
  logic w_taken;

  assign w_eq  = (rs1 == rs2);
  assign w_lt  = ($signed(rs1) < $signed(rs2));
  assign w_ltu = (rs1 < rs2);

  always_comb begin
    w_taken = 1'b0;
    case (op)
      c_OP_EQ:   w_taken = w_eq;
      c_OP_NE:   w_taken = ~w_eq;
      c_OP_LT:   w_taken = w_lt;
      c_OP_LTU:  w_taken = w_ltu;
      c_OP_GE:   w_taken = ~w_lt;
      c_OP_GEU:  w_taken = ~w_ltu;
      c_OP_JAL:  w_taken = 1'b1;
      c_OP_JALR: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Target / next PC / link PC (all arithmetic wraps modulo 2^XLEN)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_mispredict;

  assign w_pc_plus4  = pc + XLEN'(4);
  assign w_pc_target = pc + imm;
  assign w_jalr_sum  = rs1 + imm;
  assign w_target    = (op == c_OP_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_target;
  assign w_next_pc   = w_taken ? w_target : w_pc_plus4;
  // Comparing here and registering the result is equivalent to comparing the
  // registered next_pc against a registered copy of pred_next_pc.
  assign w_mispredict = (w_next_pc != pred_next_pc);

  // --------------------------------------------------------------------------
  // Request acceptance
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_is_cond;
  logic w_bht_upd;

  assign w_accept  = valid_in & ~stall & ~flush;
  // Ops 000..101 are conditional branches; 110/111 are jumps.
  assign w_is_cond = ~(op[2] & op[1]);
  assign w_bht_upd = w_accept & w_is_cond;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic            r_valid;
  logic            r_taken;
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] r_link_pc;
  logic            r_mispredict;
  logic [15:0]     r_mp_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_next_pc    <= '0;
      r_link_pc    <= '0;
      r_mispredict <= 1'b0;
    end else if (flush) begin
      // Flush wins over stall; payload fields are don't-care once invalid.
      r_valid      <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (!stall) begin
      r_valid      <= valid_in;
      r_taken      <= w_taken;
      r_next_pc    <= w_next_pc;
      r_link_pc    <= w_pc_plus4;
      r_mispredict <= valid_in & w_mispredict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mp_count <= 16'h0000;
    end else if (w_accept && w_mispredict && (r_mp_count != 16'hFFFF)) begin
      r_mp_count <= r_mp_count + 16'h0001;
    end
  end

  assign valid_out        = r_valid;
  assign taken            = r_taken;
  assign next_pc          = r_next_pc;
  assign link_pc          = r_link_pc;
  assign mispredict       = r_mispredict;
  assign mispredict_count = r_mp_count;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  logic [1:0]         r_bht [c_BHT_ENTRIES];
  logic [BHT_IDX-1:0] w_upd_idx;
  logic [BHT_IDX-1:0] w_lkp_idx;
  logic               w_unused_lookup;

  assign w_upd_idx = pc[BHT_IDX+1:2];
  assign w_lkp_idx = lookup_pc[BHT_IDX+1:2];
  // Only the index bits of lookup_pc select an entry.
  assign w_unused_lookup = ^{lookup_pc[XLEN-1:BHT_IDX+2], lookup_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_upd) begin
      if (w_taken) begin
        if (r_bht[w_upd_idx] != 2'b11) r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
      end else begin
        if (r_bht[w_upd_idx] != 2'b00) r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
      end
    end
  end

  // Reads the registered table, so a same-cycle update is not visible yet.
  assign predict_taken = r_bht[w_lkp_idx][1];

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_unit
//  Purpose  : Directed self-checking bench for branch_unit (XLEN=32,
//             BHT_IDX=4). Each task drives one scenario and checks inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [31:0] pred_next_pc;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic        valid_out;
  logic        taken;
  logic [31:0] next_pc;
  logic [31:0] link_pc;
  logic        mispredict;
  logic [15:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  branch_unit #(.XLEN(32), .BHT_IDX(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .stall            (stall),
    .flush            (flush),
    .op               (op),
    .pc               (pc),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .pred_next_pc     (pred_next_pc),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .valid_out        (valid_out),
    .taken            (taken),
    .next_pc          (next_pc),
    .link_pc          (link_pc),
    .mispredict       (mispredict),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i, input logic [31:0] pr);
    valid_in = 1'b1; op = o; pc = p; rs1 = a; rs2 = b; imm = i; pred_next_pc = pr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; op = 3'b000;
    pc = '0; rs1 = '0; rs2 = '0; imm = '0; pred_next_pc = '0; lookup_pc = 32'h40;
    #2;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", valid_out); end
    total++; if (next_pc !== 32'h0 || link_pc !== 32'h0) begin bad++; $display("FAIL rst_pcs: got %h/%h want 0/0", next_pc, link_pc); end
    total++; if (mispredict_count !== 16'h0) begin bad++; $display("FAIL rst_count: got %0d want 0", mispredict_count); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL rst_predict: got %0b want 0", predict_taken); end
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic test_compare();
    // pc 0x108 uses BHT index 2, away from the entries checked later.
    drive(3'b010, 32'h108, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h128); tick();
    total++; if (valid_out !== 1'b1 || taken !== 1'b1) begin bad++; $display("FAIL lt_taken: got v=%0b t=%0b want 1/1", valid_out, taken); end
    total++; if (next_pc !== 32'h128) begin bad++; $display("FAIL lt_next: got %h want 00000128", next_pc); end
    drive(3'b011, 32'h108, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h10C); tick();
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL ltu_taken: got %0b want 0", taken); end
    total++; if (next_pc !== 32'h10C || link_pc !== 32'h10C) begin bad++; $display("FAIL ltu_pcs: got %h/%h want 0000010c/0000010c", next_pc, link_pc); end
    drive(3'b100, 32'h108, 32'h5, 32'h5, 32'h20, 32'h128); tick();
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL ge_equal: got %0b want 1", taken); end
    drive(3'b101, 32'h108, 32'h1, 32'hFFFF_FFFF, 32'h20, 32'h10C); tick();
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL geu_taken: got %0b want 0", taken); end
    drive(3'b001, 32'h108, 32'h5, 32'h6, 32'h20, 32'h128); tick();
    total++; if (taken !== 1'b1 || mispredict !== 1'b0) begin bad++; $display("FAIL ne_taken: got t=%0b m=%0b want 1/0", taken, mispredict); end
    total++; if (mispredict_count !== 16'd0) begin bad++; $display("FAIL cmp_count: got %0d want 0", mispredict_count); end
  endtask

  task automatic test_jalr();
    drive(3'b111, 32'h200, 32'h1003, 32'h0, 32'h4, 32'h204); tick();
    total++; if (next_pc !== 32'h1006) begin bad++; $display("FAIL jalr_next: got %h want 00001006", next_pc); end
    total++; if (link_pc !== 32'h204) begin bad++; $display("FAIL jalr_link: got %h want 00000204", link_pc); end
    total++; if (mispredict !== 1'b1 || taken !== 1'b1) begin bad++; $display("FAIL jalr_mp: got m=%0b t=%0b want 1/1", mispredict, taken); end
    total++; if (mispredict_count !== 16'd1) begin bad++; $display("FAIL jalr_count: got %0d want 1", mispredict_count); end
    valid_in = 1'b0; tick();
    total++; if (valid_out !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL idle_out: got v=%0b m=%0b want 0/0", valid_out, mispredict); end
  endtask

  task automatic test_bht();
    lookup_pc = 32'h40;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL bht_init: got %0b want 0", predict_taken); end
    drive(3'b000, 32'h40, 32'h7, 32'h7, 32'h10, 32'h50);
    #1;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL bht_rbw: got %0b want 0", predict_taken); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL bht_train%0d: got %0b want 1", k, predict_taken); end
    end
    // 0x44 is index 1 and untouched; 0x80 shares index 0 with 0x40.
    lookup_pc = 32'h44; #1;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL bht_other: got %0b want 0", predict_taken); end
    lookup_pc = 32'h80; #1;
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL bht_alias: got %0b want 1", predict_taken); end
    // Saturated at 11: one not-taken leaves 10 (still taken), a second gives 01.
    lookup_pc = 32'h40;
    drive(3'b001, 32'h40, 32'h7, 32'h7, 32'h10, 32'h44); tick();
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL bht_sat: got %0b want 1", predict_taken); end
    tick();
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL bht_dec: got %0b want 0", predict_taken); end
    valid_in = 1'b0;
  endtask

  task automatic test_stall_flush();
    drive(3'b000, 32'h3C, 32'h1, 32'h2, 32'h10, 32'h40); tick();
    total++; if (valid_out !== 1'b1 || next_pc !== 32'h40) begin bad++; $display("FAIL st_setup: got v=%0b n=%h want 1/00000040", valid_out, next_pc); end
    // Taken, mispredicting BEQ at 0x40: would train index 0 and count if accepted.
    drive(3'b000, 32'h40, 32'h9, 32'h9, 32'h10, 32'h0);
    stall = 1'b1; lookup_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (valid_out !== 1'b1 || next_pc !== 32'h40 || taken !== 1'b0) begin bad++; $display("FAIL st_hold%0d: got v=%0b n=%h t=%0b want 1/00000040/0", k, valid_out, next_pc, taken); end
      total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL st_bht%0d: got %0b want 0", k, predict_taken); end
    end
    flush = 1'b1; tick();
    total++; if (valid_out !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL flush_stall: got v=%0b m=%0b want 0/0", valid_out, mispredict); end
    stall = 1'b0; tick();
    total++; if (valid_out !== 1'b0 || mispredict_count !== 16'd1) begin bad++; $display("FAIL flush_in: got v=%0b c=%0d want 0/1", valid_out, mispredict_count); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL flush_bht: got %0b want 0", predict_taken); end
    flush = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_wrap();
    drive(3'b001, 32'hFFFF_FFFC, 32'h3, 32'h3, 32'h8, 32'h0); tick();
    total++; if (next_pc !== 32'h0 || link_pc !== 32'h0) begin bad++; $display("FAIL wrap_pcs: got %h/%h want 0/0", next_pc, link_pc); end
    total++; if (taken !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL wrap_flags: got t=%0b m=%0b want 0/0", taken, mispredict); end
    valid_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    lookup_pc = 32'h0C;
    for (int k = 0; k < 6; k++) begin
      drive(3'b000, 32'h0C, 32'h4, 32'h4, 32'h100, 32'h0); tick();
      total++; if (next_pc !== 32'h10C || mispredict !== 1'b1 || mispredict_count !== 16'(2 + k)) begin
        bad++; $display("FAIL b2b%0d: got n=%h m=%0b c=%0d want 0000010c/1/%0d", k, next_pc, mispredict, mispredict_count, 2 + k);
      end
    end
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL b2b_bht: got %0b want 1", predict_taken); end
  endtask

  task automatic test_async_reset();
    total++; if (valid_out !== 1'b1 || mispredict_count !== 16'd7) begin bad++; $display("FAIL ar_pre: got v=%0b c=%0d want 1/7", valid_out, mispredict_count); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0 || mispredict_count !== 16'd0) begin bad++; $display("FAIL ar_now: got v=%0b c=%0d want 0/0", valid_out, mispredict_count); end
    total++; if (mispredict !== 1'b0 || taken !== 1'b0 || next_pc !== 32'h0 || link_pc !== 32'h0) begin
      bad++; $display("FAIL ar_fields: got m=%0b t=%0b n=%h l=%h want 0/0/0/0", mispredict, taken, next_pc, link_pc);
    end
    for (int k = 0; k < 16; k++) begin
      lookup_pc = 32'(k) << 2; #1;
      total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL ar_bht%0d: got %0b want 0", k, predict_taken); end
    end
    valid_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL ar_first_idle: got %0b want 0", valid_out); end
    drive(3'b110, 32'h500, 32'h0, 32'h0, 32'h40, 32'h540); tick();
    total++; if (valid_out !== 1'b1 || next_pc !== 32'h540 || link_pc !== 32'h504) begin
      bad++; $display("FAIL ar_first_req: got v=%0b n=%h l=%h want 1/00000540/00000504", valid_out, next_pc, link_pc);
    end
    total++; if (mispredict !== 1'b0 || mispredict_count !== 16'd0) begin bad++; $display("FAIL ar_first_mp: got m=%0b c=%0d want 0/0", mispredict, mispredict_count); end
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_compare();
    test_jalr();
    test_bht();
    test_stall_flush();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
